// File: rtl/toggle_shift_pipe_pkg.sv
// rtl/toggle_shift_pipe_pkg.sv - shared state encoding and default parameters for toggle_shift_pipe
package toggle_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tsp_state_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_OR_LAT   = 2;

endpackage

// File: rtl/toggle_shift_pipe_delay_line.sv
// rtl/toggle_shift_pipe_delay_line.sv - generic async-reset register chain, STAGES=0 passes through
module tsp_delay_line #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] dout,
    output logic             head_match
);

    // head_match: every stage except the last equals cmp, so one more shift of
    // an unchanging cmp leaves the whole chain uniform.
    generate
        if (STAGES == 0) begin : g_pass
            logic pass_unused;
            assign pass_unused = ^{clk, rst_n, cmp};
            assign dout        = din;
            assign head_match  = 1'b1;
        end else begin : g_regs
            logic [WIDTH-1:0] stage [STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < STAGES; k++) stage[k] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
                end
            end

            always_comb begin
                head_match = 1'b1;
                for (int k = 0; k < STAGES - 1; k++) begin
                    if (stage[k] != cmp) head_match = 1'b0;
                end
            end

            if (STAGES == 1) begin : g_single
                logic single_unused;
                assign single_unused = ^cmp;
            end

            assign dout = stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/toggle_shift_pipe.sv
// rtl/toggle_shift_pipe.sv - multi-channel toggle/shift/OR pipeline with run/drain FSM; optional FORCE_OVERRIDE_EN tap force
module toggle_shift_pipe
    import toggle_shift_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int OR_LAT   = DEF_OR_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [CHANNELS-1:0] toggle_en,
`ifdef FORCE_OVERRIDE_EN
    input  logic [CHANNELS-1:0] force_en,
    input  logic [CHANNELS-1:0] force_val,
`endif
    output logic                busy,
    output logic [CHANNELS-1:0] tog_q,
    output logic [CHANNELS-1:0] tap_q,
    output logic [CHANNELS-1:0] chg_pulse,
    output logic [CHANNELS-1:0] or_out
);

    tsp_state_t          state;
    logic [CHANNELS-1:0] tog_next;
    logic [CHANNELS-1:0] stage_tap;
    logic [CHANNELS-1:0] or_in;
    logic                line_settled;
    logic                or_pipe_unused;

    // Stop outranks start in every state; DRAIN leaves once the shift line
    // will hold the frozen toggle value everywhere after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (stop) begin
                        state <= ST_DRAIN;
                    end else if (start) begin
                        state <= ST_RUN;
                    end else if (line_settled) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tog_next = (state == ST_RUN) ? (tog_q ^ toggle_en) : tog_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q     <= '0;
            chg_pulse <= '0;
        end else begin
            tog_q     <= tog_next;
            chg_pulse <= tog_next ^ tog_q;
        end
    end

    tsp_delay_line #(
        .WIDTH  (CHANNELS),
        .STAGES (DEPTH)
    ) u_shift_line (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (tog_q),
        .cmp        (tog_q),
        .dout       (stage_tap),
        .head_match (line_settled)
    );

`ifdef FORCE_OVERRIDE_EN
    // Force only masks the tap; the line underneath keeps shifting.
    assign tap_q = (force_en & force_val) | (~force_en & stage_tap);
`else
    assign tap_q = stage_tap;
`endif

    assign or_in = tog_q | tap_q;

    tsp_delay_line #(
        .WIDTH  (CHANNELS),
        .STAGES (OR_LAT)
    ) u_or_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (or_in),
        .cmp        ({CHANNELS{1'b0}}),
        .dout       (or_out),
        .head_match (or_pipe_unused)
    );

endmodule

// File: tb/tb_toggle_shift_pipe.sv
// tb/tb_toggle_shift_pipe.sv - table-driven self-checking bench for toggle_shift_pipe (DEPTH=2, OR_LAT=2)
module tb_toggle_shift_pipe;

    localparam int CH = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [CH-1:0] toggle_en;
    logic          busy;
    logic [CH-1:0] tog_q;
    logic [CH-1:0] tap_q;
    logic [CH-1:0] chg_pulse;
    logic [CH-1:0] or_out;
`ifdef FORCE_OVERRIDE_EN
    logic [CH-1:0] force_en;
    logic [CH-1:0] force_val;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    toggle_shift_pipe #(
        .CHANNELS (CH),
        .DEPTH    (2),
        .OR_LAT   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .toggle_en (toggle_en),
`ifdef FORCE_OVERRIDE_EN
        .force_en  (force_en),
        .force_val (force_val),
`endif
        .busy      (busy),
        .tog_q     (tog_q),
        .tap_q     (tap_q),
        .chg_pulse (chg_pulse),
        .or_out    (or_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          start;
        logic          stop;
        logic [CH-1:0] en;
        logic          busy;
        logic [CH-1:0] tog;
        logic [CH-1:0] tap;
        logic [CH-1:0] chg;
        logic [CH-1:0] orv;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic b, input logic [CH-1:0] t,
                           input logic [CH-1:0] p, input logic [CH-1:0] c, input logic [CH-1:0] o);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".tog_q"}, 32'(tog_q), 32'(t));
        chk({tag, ".tap_q"}, 32'(tap_q), 32'(p));
        chk({tag, ".chg_pulse"}, 32'(chg_pulse), 32'(c));
        chk({tag, ".or_out"}, 32'(or_out), 32'(o));
    endtask

    initial begin
        //          start stop en     busy tog   tap   chg   or
        vecs[0]  = {1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = {1'b0, 1'b0, 4'h1, 1'b1, 4'h1, 4'h0, 4'h1, 4'h0};
        vecs[2]  = {1'b0, 1'b0, 4'h1, 1'b1, 4'h0, 4'h0, 4'h1, 4'h0};
        vecs[3]  = {1'b0, 1'b0, 4'h1, 1'b1, 4'h1, 4'h1, 4'h1, 4'h1};
        vecs[4]  = {1'b0, 1'b0, 4'h2, 1'b1, 4'h3, 4'h0, 4'h2, 4'h0};
        vecs[5]  = {1'b0, 1'b0, 4'h0, 1'b1, 4'h3, 4'h1, 4'h0, 4'h1};
        vecs[6]  = {1'b0, 1'b0, 4'h0, 1'b1, 4'h3, 4'h3, 4'h0, 4'h3};
        vecs[7]  = {1'b0, 1'b0, 4'h2, 1'b1, 4'h1, 4'h3, 4'h2, 4'h3};
        vecs[8]  = {1'b0, 1'b1, 4'h1, 1'b1, 4'h0, 4'h3, 4'h1, 4'h3};
        vecs[9]  = {1'b0, 1'b0, 4'hF, 1'b1, 4'h0, 4'h1, 4'h0, 4'h3};
        vecs[10] = {1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h3};
        vecs[11] = {1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1};
        vecs[12] = {1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[13] = {1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[14] = {1'b0, 1'b0, 4'h4, 1'b1, 4'h4, 4'h0, 4'h4, 4'h0};
        vecs[15] = {1'b0, 1'b1, 4'h4, 1'b1, 4'h0, 4'h0, 4'h4, 4'h0};
        vecs[16] = {1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 4'h4, 4'h0, 4'h4};
        vecs[17] = {1'b0, 1'b0, 4'h8, 1'b1, 4'h8, 4'h0, 4'h8, 4'h0};
        vecs[18] = {1'b0, 1'b1, 4'h0, 1'b1, 4'h8, 4'h0, 4'h0, 4'h4};
        vecs[19] = {1'b0, 1'b0, 4'h0, 1'b0, 4'h8, 4'h8, 4'h0, 4'h8};
        vecs[20] = {1'b0, 1'b0, 4'h0, 1'b0, 4'h8, 4'h8, 4'h0, 4'h8};

        rst_n     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        toggle_en = '0;
`ifdef FORCE_OVERRIDE_EN
        force_en  = '0;
        force_val = '0;
`endif
        #12;
        chk_all("reset", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            start     = vecs[i].start;
            stop      = vecs[i].stop;
            toggle_en = vecs[i].en;
            step();
            chk_all($sformatf("row%0d", i), vecs[i].busy, vecs[i].tog, vecs[i].tap,
                    vecs[i].chg, vecs[i].orv);
        end

        // Asynchronous reset in the middle of RUN with tog_q = 4'b1010.
        start = 1'b1; stop = 1'b0; toggle_en = 4'h0;
        step();
        start = 1'b0; toggle_en = 4'h2;
        step();
        chk("pre_reset.tog_q", 32'(tog_q), 32'hA);
        chk("pre_reset.busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        #2 rst_n = 1'b1;
        toggle_en = 4'hF;
        step();
        chk("post_reset_idle.busy", 32'(busy), 32'h0);
        chk("post_reset_idle.tog_q", 32'(tog_q), 32'h0);
        toggle_en = 4'h0;

`ifdef FORCE_OVERRIDE_EN
        force_en = 4'hF; force_val = 4'hF;
        #1;
        chk("force.tap_now", 32'(tap_q), 32'hF);
        chk("force.or_not_yet", 32'(or_out), 32'h0);
        step();
        step();
        chk("force.or_after_lat", 32'(or_out), 32'hF);
        chk("force.tap_held", 32'(tap_q), 32'hF);
        force_en = 4'h0;
        #1;
        chk("force.release_tap", 32'(tap_q), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
